// File: rtl/drink_dispenser_if.sv
// Handshake bundle between the vending controller and the drink dispenser.
// The controller side is the master; the dispenser side is the slave.
interface drink_dispenser_if;
    logic       drink_contral;
    logic       drink_sensed;
    logic       drink_out_fin;
    logic       motor_on;
    logic [3:0] stock;
    logic       empty;
    logic       fault;

    modport master (
        output drink_contral,
        output drink_sensed,
        input  drink_out_fin,
        input  motor_on,
        input  stock,
        input  empty,
        input  fault
    );

    modport slave (
        input  drink_contral,
        input  drink_sensed,
        output drink_out_fin,
        output motor_on,
        output stock,
        output empty,
        output fault
    );
endinterface

// File: rtl/drink_dispenser.sv
// Drink dispenser controller: runs the motor for a fixed time on a request
// edge, waits for the drop sensor, strobes completion and tracks stock.
module drink_dispenser #(
    parameter int DISPENSE_CYCLES = 8,
    parameter int DROP_TIMEOUT    = 16,
    parameter int STOCK_INIT      = 10
) (
    input  logic               sclk,
    input  logic               srst_n,
    drink_dispenser_if.slave   bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RUN     = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

    localparam logic [7:0] RUN_LEN      = 8'(DISPENSE_CYCLES);
    localparam logic [7:0] TIMEOUT_LAST = 8'(DROP_TIMEOUT - 1);
    localparam logic [3:0] STOCK_RST    = 4'(STOCK_INIT);

    logic [2:0] state_reg,  state_next;
    logic [7:0] cnt_reg,    cnt_next;
    logic       motor_reg,  motor_next;
    logic       fin_reg,    fin_next;
    logic [3:0] stock_reg,  stock_next;
    logic       empty_reg,  empty_next;
    logic       fault_reg,  fault_next;
    logic       req_d_reg;
    logic       req_edge;

    assign req_edge = bus.drink_contral & ~req_d_reg;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        motor_next = motor_reg;
        fin_next   = 1'b1;
        stock_next = stock_reg;
        empty_next = empty_reg;
        fault_next = fault_reg;
        case (state_reg)
            S_IDLE: begin
                motor_next = 1'b0;
                if (req_edge && stock_reg != 4'd0) begin
                    state_next = S_RUN;
                    cnt_next   = 8'd0;
                end
            end
            S_RUN: begin
                // Motor rises one edge after entering RUN, so the count
                // runs 0..RUN_LEN with the last step turning it off.
                if (!bus.drink_contral) begin
                    motor_next = 1'b0;
                    state_next = S_IDLE;
                    cnt_next   = 8'd0;
                end else if (cnt_reg == RUN_LEN) begin
                    motor_next = 1'b0;
                    state_next = S_WAIT;
                    cnt_next   = 8'd0;
                end else begin
                    motor_next = 1'b1;
                    cnt_next   = cnt_reg + 8'd1;
                end
            end
            S_WAIT: begin
                motor_next = 1'b0;
                if (bus.drink_sensed) begin
                    state_next = S_DONE;
                    fin_next   = 1'b0;
                    cnt_next   = 8'd0;
                    if (stock_reg != 4'd0) begin
                        stock_next = stock_reg - 4'd1;
                        empty_next = (stock_reg == 4'd1);
                    end
                end else if (cnt_reg == TIMEOUT_LAST) begin
                    state_next = S_FAULT;
                    fault_next = 1'b1;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            S_DONE: begin
                state_next = S_RELEASE;
            end
            S_RELEASE: begin
                if (!bus.drink_contral) begin
                    state_next = S_IDLE;
                end
            end
            S_FAULT: begin
                motor_next = 1'b0;
                fault_next = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
                motor_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (!srst_n) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 8'd0;
            motor_reg <= 1'b0;
            fin_reg   <= 1'b1;
            stock_reg <= STOCK_RST;
            empty_reg <= (STOCK_RST == 4'd0);
            fault_reg <= 1'b0;
            req_d_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            motor_reg <= motor_next;
            fin_reg   <= fin_next;
            stock_reg <= stock_next;
            empty_reg <= empty_next;
            fault_reg <= fault_next;
            req_d_reg <= bus.drink_contral;
        end
    end

    assign bus.motor_on      = motor_reg;
    assign bus.drink_out_fin = fin_reg;
    assign bus.stock         = stock_reg;
    assign bus.empty         = empty_reg;
    assign bus.fault         = fault_reg;

endmodule
